operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Register-read / operand-fetch stage between instruction decode and the ALU/execute stage of the 8-bit CPU.
- Drives the register file read addresses and takes its combinational read data.
- Resolves data hazards by forwarding from EX and WB, and stalls on load-use.
- Delivers one registered operand packet per instruction to execute over a valid/ready handshake.

Parameters:
DATA_W, 8, datapath and register width
ADDR_W, 3, register index width (8 registers, r0 hard-wired zero)
OP_W, 3, ALU opcode width
CNT_W, 16, stall counter width (optional feature only)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage accepts the instruction this cycle
in_rs1  in  ADDR_W  source register 1
in_rs2  in  ADDR_W  source register 2
in_rd  in  ADDR_W  destination register
in_regWrite  in  1  instruction writes rd
in_memRead  in  1  instruction is a load
in_useImm  in  1  operand B is the immediate; rs2 is unused
in_imm  in  DATA_W  immediate
in_aluOp  in  OP_W  ALU operation
readRegister1  out  ADDR_W  register file read address 1
readRegister2  out  ADDR_W  register file read address 2
readData1  in  DATA_W  register file read data 1
readData2  in  DATA_W  register file read data 2
ex_regWrite  in  1  instruction in EX writes a register
ex_memRead  in  1  instruction in EX is a load
ex_rd  in  ADDR_W  EX destination
ex_result  in  DATA_W  EX ALU result
wb_regWrite  in  1  register file write this cycle
wb_rd  in  ADDR_W  write register
wb_data  in  DATA_W  write data
flush  in  1  discard the held and incoming instruction (branch taken)
out_valid  out  1  operand packet valid
out_ready  in  1  execute accepts the packet
out_opA  out  DATA_W  operand A
out_opB  out  DATA_W  operand B
out_rd  out  ADDR_W  destination
out_regWrite  out  1  passthrough
out_memRead  out  1  passthrough
out_aluOp  out  OP_W  passthrough

Behaviour:
- readRegister1 = in_rs1 and readRegister2 = in_rs2, combinational, no gating.
- Source value per rs, highest priority first:
  - rs==0 -> 0.
  - ex_regWrite && !ex_memRead && ex_rd==rs -> ex_result.
  - wb_regWrite && wb_rd==rs -> wb_data. The register file's read data still shows the old value in the write cycle, so this bypass is mandatory.
  - otherwise readData.
- opA = src(rs1). opB = in_useImm ? in_imm : src(rs2).
- hazard = in_valid && ex_regWrite && ex_memRead && ex_rd!=0 && (ex_rd==in_rs1 || (!in_useImm && ex_rd==in_rs2)).
- slot_free = !out_valid || out_ready.
- in_ready = slot_free && !hazard && !flush, combinational.
- Output register updates on the rising clock edge:
  - flush: out_valid<=0; incoming instruction not accepted.
  - else if slot_free: out_valid<=in_valid && !hazard; payload loads when in_valid && in_ready.
  - else: hold all outputs unchanged. Outputs must stay stable while out_valid && !out_ready.
- Load-use: exactly one bubble (out_valid=0) per load cycle in EX. On the following cycle the load is in WB and is forwarded through the wb path.
- Latency: 1 cycle from acceptance to out_valid. Throughput: 1 instruction per cycle with no hazards.
- Reset (asynchronous, any time including mid-stall): out_valid=0 and all payload outputs 0. in_ready follows the combinational equation.
- Simultaneous EX and WB match on the same rs: EX wins (younger).
- No forwarding or stall when rs or rd is 0.

Optional Feature:
- Macro STALL_COUNTER_EN.
- Defined: adds output perf_stalls [CNT_W-1:0], reset to 0.
  - Increments by 1 each cycle that in_valid && !in_ready && !flush.
  - Saturates at all-ones.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Reset: assert reset_n=0 mid-transfer -> out_valid=0, out_opA=out_opB=0 immediately; release, in_ready=1.
- Plain issue: rs1=2 (readData1=0x11), rs2=3 (readData2=0x22), useImm=0 -> next cycle out_opA=0x11, out_opB=0x22, out_valid=1.
- EX forward over WB: rs1=4, ex_regWrite=1, ex_rd=4, ex_result=0xA5, wb_rd=4, wb_data=0x5A -> out_opA=0xA5.
- WB bypass: wb_regWrite=1, wb_rd=5, wb_data=0x3C, readData2=0x00, rs2=5 -> out_opB=0x3C. With rs2=0 -> out_opB=0.
- Load-use stall: ex_memRead=1, ex_rd=1, rs1=1 -> in_ready=0, one bubble cycle. Next cycle wb_rd=1, wb_data=0x77 -> out_opA=0x77.
- Backpressure and flush: out_ready=0 for 3 cycles -> outputs held, in_ready=0. Then flush=1 -> out_valid=0 next cycle.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand fetch: register read, EX/WB forwarding, load-use stall, one-entry output slot.
// Optional: define STALL_COUNTER_EN to add the perf_stalls saturating stall counter.
module operand_fetch #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int OP_W   = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
`ifdef STALL_COUNTER_EN
  output logic [CNT_W-1:0]  perf_stalls,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_regWrite,
  input  logic              in_memRead,
  input  logic              in_useImm,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [OP_W-1:0]   in_aluOp,
  output logic [ADDR_W-1:0] readRegister1,
  output logic [ADDR_W-1:0] readRegister2,
  input  logic [DATA_W-1:0] readData1,
  input  logic [DATA_W-1:0] readData2,
  input  logic              ex_regWrite,
  input  logic              ex_memRead,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              wb_regWrite,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_opA,
  output logic [DATA_W-1:0] out_opB,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_regWrite,
  output logic              out_memRead,
  output logic [OP_W-1:0]   out_aluOp
);

  logic              exFwd;
  logic              hazard;
  logic              slotFree;
  logic              accept;
  logic [DATA_W-1:0] srcA;
  logic [DATA_W-1:0] srcB;

  // EX beats WB: it holds the younger value for the same register.
  function automatic logic [DATA_W-1:0] pick(
    input logic [ADDR_W-1:0] rs,
    input logic [DATA_W-1:0] rf,
    input logic              exOk,
    input logic [ADDR_W-1:0] exRd,
    input logic [DATA_W-1:0] exVal,
    input logic              wbOk,
    input logic [ADDR_W-1:0] wbRd,
    input logic [DATA_W-1:0] wbVal
  );
    if (rs == '0)
      return '0;
    if (exOk && exRd == rs)
      return exVal;
    if (wbOk && wbRd == rs)
      return wbVal;
    return rf;
  endfunction

  assign readRegister1 = in_rs1;
  assign readRegister2 = in_rs2;

  // A load in EX has no result yet, so it never forwards.
  assign exFwd = ex_regWrite && !ex_memRead;

  // Operand selection with forwarding; immediate replaces operand B.
  always_comb begin
    srcA = pick(in_rs1, readData1, exFwd, ex_rd, ex_result,
                wb_regWrite, wb_rd, wb_data);
    srcB = pick(in_rs2, readData2, exFwd, ex_rd, ex_result,
                wb_regWrite, wb_rd, wb_data);
    if (in_useImm)
      srcB = in_imm;
  end

  assign hazard = in_valid && ex_regWrite && ex_memRead &&
                  (ex_rd != '0) &&
                  ((ex_rd == in_rs1) ||
                   (!in_useImm && ex_rd == in_rs2));

  assign slotFree = !out_valid || out_ready;
  assign in_ready = slotFree && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  // Output slot: flush kills, free slot refills, full slot holds.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid    <= 1'b0;
      out_opA      <= '0;
      out_opB      <= '0;
      out_rd       <= '0;
      out_regWrite <= 1'b0;
      out_memRead  <= 1'b0;
      out_aluOp    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (slotFree) begin
      out_valid <= in_valid && !hazard;
      if (accept) begin
        out_opA      <= srcA;
        out_opB      <= srcB;
        out_rd       <= in_rd;
        out_regWrite <= in_regWrite;
        out_memRead  <= in_memRead;
        out_aluOp    <= in_aluOp;
      end
    end
  end

`ifdef STALL_COUNTER_EN
  // Count cycles where decode is blocked, saturating at all-ones.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      perf_stalls <= '0;
    else if (in_valid && !in_ready && !flush &&
             perf_stalls != '1)
      perf_stalls <= perf_stalls + 1'b1;
  end
`else
  logic [CNT_W-1:0] unusedCnt;
  assign unusedCnt = '0;
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed test-plan steps, then random traffic
// checked against a one-entry queue model of the output slot.
module tb_operand_fetch;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int OW = 3;
  localparam int CW = 16;

  typedef struct {
    logic [DW-1:0] opA;
    logic [DW-1:0] opB;
    logic [AW-1:0] rd;
    logic          regWrite;
    logic          memRead;
    logic [OW-1:0] aluOp;
  } pkt_t;

  logic          clock;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rs1;
  logic [AW-1:0] in_rs2;
  logic [AW-1:0] in_rd;
  logic          in_regWrite;
  logic          in_memRead;
  logic          in_useImm;
  logic [DW-1:0] in_imm;
  logic [OW-1:0] in_aluOp;
  logic [AW-1:0] readRegister1;
  logic [AW-1:0] readRegister2;
  logic [DW-1:0] readData1;
  logic [DW-1:0] readData2;
  logic          ex_regWrite;
  logic          ex_memRead;
  logic [AW-1:0] ex_rd;
  logic [DW-1:0] ex_result;
  logic          wb_regWrite;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_opA;
  logic [DW-1:0] out_opB;
  logic [AW-1:0] out_rd;
  logic          out_regWrite;
  logic          out_memRead;
  logic [OW-1:0] out_aluOp;
`ifdef STALL_COUNTER_EN
  logic [CW-1:0] perfStalls;
  int            mdlStalls;
`endif

  logic [DW-1:0] regs [8];
  pkt_t          slot [$];
  int            tests;
  int            fails;

  assign readData1 = regs[readRegister1];
  assign readData2 = regs[readRegister2];

  operand_fetch #(
    .DATA_W(DW), .ADDR_W(AW), .OP_W(OW), .CNT_W(CW)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
`ifdef STALL_COUNTER_EN
    .perf_stalls(perfStalls),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_rs1(in_rs1),
    .in_rs2(in_rs2),
    .in_rd(in_rd),
    .in_regWrite(in_regWrite),
    .in_memRead(in_memRead),
    .in_useImm(in_useImm),
    .in_imm(in_imm),
    .in_aluOp(in_aluOp),
    .readRegister1(readRegister1),
    .readRegister2(readRegister2),
    .readData1(readData1),
    .readData2(readData2),
    .ex_regWrite(ex_regWrite),
    .ex_memRead(ex_memRead),
    .ex_rd(ex_rd),
    .ex_result(ex_result),
    .wb_regWrite(wb_regWrite),
    .wb_rd(wb_rd),
    .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_opA(out_opA),
    .out_opB(out_opB),
    .out_rd(out_rd),
    .out_regWrite(out_regWrite),
    .out_memRead(out_memRead),
    .out_aluOp(out_aluOp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value a source register should deliver right now.
  function automatic logic [DW-1:0] val(input logic [AW-1:0] r);
    logic [DW-1:0] v;
    v = regs[r];
    if (wb_regWrite && wb_rd == r) v = wb_data;
    if (ex_regWrite && !ex_memRead && ex_rd == r) v = ex_result;
    if (r == 0) v = '0;
    return v;
  endfunction

  task automatic idle();
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    in_regWrite = 0; in_memRead = 0; in_useImm = 0;
    in_imm = 0; in_aluOp = 0;
    ex_regWrite = 0; ex_memRead = 0; ex_rd = 0; ex_result = 0;
    wb_regWrite = 0; wb_rd = 0; wb_data = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic chkOut();
    chk("out_valid", out_valid, slot.size() != 0);
    if (slot.size() != 0) begin
      chk("out_opA", out_opA, slot[0].opA);
      chk("out_opB", out_opB, slot[0].opB);
      chk("out_rd", out_rd, slot[0].rd);
      chk("out_regWrite", out_regWrite, slot[0].regWrite);
      chk("out_memRead", out_memRead, slot[0].memRead);
      chk("out_aluOp", out_aluOp, slot[0].aluOp);
    end
`ifdef STALL_COUNTER_EN
    chk("perf_stalls", perfStalls, mdlStalls);
`endif
  endtask

  // One clock: check combinational side, advance model, check outputs.
  task automatic cyc();
    logic haz, rdy, free, stall;
    logic wbW;
    logic [AW-1:0] wbR;
    logic [DW-1:0] wbD;
    pkt_t p;
    #1;
    haz = in_valid && ex_regWrite && ex_memRead && ex_rd != 0 &&
          (ex_rd == in_rs1 || (!in_useImm && ex_rd == in_rs2));
    free = slot.size() == 0 || out_ready;
    rdy = free && !haz && !flush;
    stall = in_valid && !rdy && !flush;
    chk("in_ready", in_ready, rdy);
    chk("readRegister1", readRegister1, in_rs1);
    chk("readRegister2", readRegister2, in_rs2);
    p.opA = val(in_rs1);
    p.opB = in_useImm ? in_imm : val(in_rs2);
    p.rd = in_rd;
    p.regWrite = in_regWrite;
    p.memRead = in_memRead;
    p.aluOp = in_aluOp;
    wbW = wb_regWrite; wbR = wb_rd; wbD = wb_data;
    @(posedge clock);
    #1;
    if (flush) slot.delete();
    else if (free) begin
      if (slot.size() != 0) void'(slot.pop_front());
      if (in_valid && rdy) slot.push_back(p);
    end
    if (wbW && wbR != 0) regs[wbR] = wbD;
`ifdef STALL_COUNTER_EN
    if (stall && mdlStalls < 65535) mdlStalls++;
`else
    if (stall) tests += 0;
`endif
    chkOut();
  endtask

  // Asynchronous reset away from any clock edge.
  task automatic midReset();
    #2 reset_n = 0;
    #1;
    slot.delete();
`ifdef STALL_COUNTER_EN
    mdlStalls = 0;
`endif
    chk("rst_valid", out_valid, 0);
    chk("rst_opA", out_opA, 0);
    chk("rst_opB", out_opB, 0);
    chk("rst_rd", out_rd, 0);
    chk("rst_aluOp", out_aluOp, 0);
    @(posedge clock);
    #1 reset_n = 1;
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic [AW-1:0] d);
    in_valid = 1; in_rs1 = a; in_rs2 = b; in_rd = d;
    in_regWrite = 1; in_useImm = 0; in_aluOp = 3'd2;
  endtask

  initial begin
    tests = 0;
    fails = 0;
`ifdef STALL_COUNTER_EN
    mdlStalls = 0;
`endif
    for (int i = 0; i < 8; i++) regs[i] = DW'(8'h40 + i);
    idle();
    reset_n = 0;
    #2;
    chk("rst0_valid", out_valid, 0);
    chk("rst0_opA", out_opA, 0);
    chk("rst0_opB", out_opB, 0);
    @(posedge clock);
    #1 reset_n = 1;
    #1 chk("rel_in_ready", in_ready, 1);
    cyc();

    // Plain issue
    regs[2] = 8'h11; regs[3] = 8'h22;
    issue(2, 3, 4);
    cyc();
    chk("plain_valid", out_valid, 1);
    chk("plain_opA", out_opA, 8'h11);
    chk("plain_opB", out_opB, 8'h22);

    // EX forwarding beats WB on the same register
    issue(4, 0, 6);
    ex_regWrite = 1; ex_rd = 4; ex_result = 8'hA5;
    wb_regWrite = 1; wb_rd = 4; wb_data = 8'h5A;
    cyc();
    chk("exfwd_opA", out_opA, 8'hA5);
    chk("exfwd_opB", out_opB, 0);

    // WB bypass while regfile still holds the old value
    idle();
    regs[5] = 8'h00;
    issue(0, 5, 1);
    wb_regWrite = 1; wb_rd = 5; wb_data = 8'h3C;
    cyc();
    chk("wbfwd_opB", out_opB, 8'h3C);
    chk("wbfwd_opA", out_opA, 0);
    in_rs2 = 0;
    cyc();
    chk("r0_opB", out_opB, 0);

    // Load-use: one bubble, then WB forwarding
    idle();
    regs[1] = 8'h99;
    issue(1, 2, 3);
    ex_regWrite = 1; ex_memRead = 1; ex_rd = 1;
    #1 chk("lu_in_ready", in_ready, 0);
    cyc();
    chk("lu_bubble", out_valid, 0);
    ex_regWrite = 0; ex_memRead = 0; ex_rd = 0;
    wb_regWrite = 1; wb_rd = 1; wb_data = 8'h77;
    cyc();
    chk("lu_valid", out_valid, 1);
    chk("lu_opA", out_opA, 8'h77);

    // Immediate hides rs2 from the load-use check
    idle();
    issue(2, 5, 3);
    in_useImm = 1; in_imm = 8'hE1;
    ex_regWrite = 1; ex_memRead = 1; ex_rd = 5;
    cyc();
    chk("imm_opB", out_opB, 8'hE1);

    // Backpressure holds, then flush empties
    idle();
    issue(2, 3, 7);
    cyc();
    out_ready = 0;
    issue(3, 2, 6);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_opA", out_opA, 8'h11);
      chk("bp_in_ready", in_ready, 0);
    end
    flush = 1;
    cyc();
    chk("flush_valid", out_valid, 0);

    // Reset in the middle of a stall
    idle();
    issue(2, 3, 7);
    cyc();
    out_ready = 0;
    cyc();
    midReset();
    idle();
    #1 chk("rst2_in_ready", in_ready, 1);
    cyc();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      in_valid    = $urandom_range(0, 3) != 0;
      in_rs1      = AW'($urandom_range(0, 7));
      in_rs2      = AW'($urandom_range(0, 7));
      in_rd       = AW'($urandom_range(0, 7));
      in_regWrite = $urandom_range(0, 1) == 1;
      in_memRead  = $urandom_range(0, 3) == 0;
      in_useImm   = $urandom_range(0, 2) == 0;
      in_imm      = DW'($urandom);
      in_aluOp    = OW'($urandom);
      ex_regWrite = $urandom_range(0, 1) == 1;
      ex_memRead  = $urandom_range(0, 3) == 0;
      ex_rd       = AW'($urandom_range(0, 7));
      ex_result   = DW'($urandom);
      wb_regWrite = $urandom_range(0, 1) == 1;
      wb_rd       = AW'($urandom_range(0, 7));
      wb_data     = DW'($urandom);
      flush       = $urandom_range(0, 15) == 0;
      out_ready   = $urandom_range(0, 3) != 0;
      if (n == 300) midReset();
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
